// File: rtl/reconfig_sequencer.sv
// reconfig_sequencer: drives the remote-update pins (cfg_ENA/cfg_CBSEL/cfg_CONFIG) with setup/pulse timing, watchdog and one golden fallback; ports: clk, rst, req, req_image, cfg_ERROR in; cfg_ENA, cfg_CBSEL, cfg_CONFIG, busy, err_code, state_o out
module reconfig_sequencer #(
  parameter int SETUP_CYC = 16,
  parameter int PULSE_CYC = 8,
  parameter int TIMEOUT_CYC = 1000000,
  parameter logic [1:0] GOLDEN_IMG = 2'd0,
  parameter bit FALLBACK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] req_image,
  input  logic       cfg_ERROR,
  output logic       cfg_ENA,
  output logic [1:0] cfg_CBSEL,
  output logic       cfg_CONFIG,
  output logic       busy,
  output logic [1:0] err_code,
  output logic [2:0] state_o
);
  localparam int MAX_SP = SETUP_CYC > PULSE_CYC ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_C = MAX_SP > TIMEOUT_CYC ? MAX_SP : TIMEOUT_CYC;
  localparam int CW = $clog2(MAX_C + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, SETUP = 3'd1, PULSE = 3'd2, WAIT = 3'd3, RECOVER = 3'd4, FAIL = 3'd5} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] img, img_n, err_n;
  logic fb, fb_n, req_q, err_s1, err_sync, req_rise;
  assign req_rise = req & ~req_q;
  assign cfg_ENA = state inside {SETUP, PULSE, WAIT};
  assign cfg_CONFIG = state == PULSE;
  assign busy = state inside {SETUP, PULSE, WAIT, RECOVER};
  assign cfg_CBSEL = img;
  assign state_o = state;
  always_comb begin
    state_n = state;
    cnt_n = '0;
    img_n = img;
    fb_n = fb;
    err_n = err_code;
    case (state)
      IDLE, FAIL: if (req_rise) begin
        state_n = SETUP;
        img_n = req_image;
        err_n = 2'b00;
        fb_n = 1'b0;
      end
      SETUP: begin
        state_n = cnt == CW'(SETUP_CYC - 1) ? PULSE : SETUP;
        cnt_n = cnt == CW'(SETUP_CYC - 1) ? '0 : cnt + 1'b1;
      end
      PULSE: begin
        state_n = cnt == CW'(PULSE_CYC - 1) ? WAIT : PULSE;
        cnt_n = cnt == CW'(PULSE_CYC - 1) ? '0 : cnt + 1'b1;
      end
      WAIT: if (err_sync) begin
        err_n = 2'b01;
        state_n = RECOVER;
      end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
        err_n = 2'b10;
        state_n = RECOVER;
      end else cnt_n = cnt + 1'b1;
      RECOVER: if (FALLBACK_EN && !fb && img != GOLDEN_IMG) begin
        img_n = GOLDEN_IMG;
        fb_n = 1'b1;
        state_n = SETUP;
      end else state_n = FAIL;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      img <= '0;
      fb <= 1'b0;
      err_code <= '0;
      req_q <= 1'b0;
      err_s1 <= 1'b0;
      err_sync <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      img <= img_n;
      fb <= fb_n;
      err_code <= err_n;
      req_q <= req;
      err_s1 <= cfg_ERROR;
      err_sync <= err_s1;
    end
  end
endmodule
